// File: rtl/mem_access_unit.sv
// MEM-stage load/store controller: word-wide DataMemory access with sub-word
// load extraction and a two-cycle read-modify-write for sub-word stores.
module mem_access_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [ADDR_W-1:0] Address,
    input  logic [31:0]       WriteData,
    input  logic              MemWrite,
    input  logic              MemRead,
    input  logic [1:0]        Size,
    input  logic              SignExt,
    output logic [ADDR_W-1:0] MemAddress,
    output logic [31:0]       MemWriteData,
    output logic              MemWriteEn,
    output logic              MemReadEn,
    input  logic [31:0]       MemReadData,
    output logic [31:0]       LoadData,
    output logic              Stall,
    output logic              AlignErr
);

    typedef enum logic {
        IDLE  = 1'b0,
        MERGE = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] merge_q, merge_d;

    logic        is_store, is_load, is_half, is_byte, is_sub, misalign;
    logic [3:0]  lane_sel;
    logic [31:0] merged_word;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [31:0] sub_ext;

    assign is_store = MemWrite;
    assign is_load  = MemRead & ~MemWrite;
    assign is_half  = (Size == 2'b01);
    assign is_byte  = (Size == 2'b10);
    assign is_sub   = is_half | is_byte;

    // Reserved size 11 falls into the word alignment rule.
    assign misalign = (is_store | is_load) &
                      ((~is_sub & (|Address[1:0])) | (is_half & Address[0]));

    assign MemAddress = {Address[ADDR_W-1:2], 2'b00};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            logic [7:0] wr_byte;
            assign lane_sel[gi] = is_byte ? (Address[1:0] == LANE) : (Address[1] == LANE[1]);
            // Odd lanes of a halfword take the upper store byte.
            assign wr_byte = (is_half && LANE[0]) ? WriteData[15:8] : WriteData[7:0];
            assign merged_word[8*gi +: 8] = lane_sel[gi] ? wr_byte : MemReadData[8*gi +: 8];
        end
    endgenerate

    assign byte_lane = MemReadData[{Address[1:0], 3'b000} +: 8];
    assign half_lane = Address[1] ? MemReadData[31:16] : MemReadData[15:0];
    assign sub_ext   = is_byte ? {{24{SignExt & byte_lane[7]}}, byte_lane}
                               : {{16{SignExt & half_lane[15]}}, half_lane};

    always_comb begin
        state_d      = state_q;
        merge_d      = merge_q;
        MemWriteEn   = 1'b0;
        MemReadEn    = 1'b0;
        MemWriteData = WriteData;
        LoadData     = '0;
        Stall        = 1'b0;
        AlignErr     = 1'b0;
        if (!Reset) begin
            case (state_q)
                IDLE: begin
                    if (misalign) begin
                        AlignErr = 1'b1;
                    end else if (is_store) begin
                        if (is_sub) begin
                            MemReadEn = 1'b1;
                            Stall     = 1'b1;
                            merge_d   = merged_word;
                            state_d   = MERGE;
                        end else begin
                            MemWriteEn = 1'b1;
                        end
                    end else if (is_load) begin
                        MemReadEn = 1'b1;
                        LoadData  = is_sub ? sub_ext : MemReadData;
                    end
                end
                MERGE: begin
                    MemWriteEn   = 1'b1;
                    MemWriteData = merge_q;
                    state_d      = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            merge_q <= '0;
        end else begin
            state_q <= state_d;
            merge_q <= merge_d;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a small word-wide DataMemory model.
module tb_mem_access_unit;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic        MemWrite;
    logic        MemRead;
    logic [1:0]  Size;
    logic        SignExt;
    logic [31:0] MemAddress;
    logic [31:0] MemWriteData;
    logic        MemWriteEn;
    logic        MemReadEn;
    logic [31:0] MemReadData;
    logic [31:0] LoadData;
    logic        Stall;
    logic        AlignErr;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] mem [0:63];

    mem_access_unit #(.ADDR_W(32)) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Address      (Address),
        .WriteData    (WriteData),
        .MemWrite     (MemWrite),
        .MemRead      (MemRead),
        .Size         (Size),
        .SignExt      (SignExt),
        .MemAddress   (MemAddress),
        .MemWriteData (MemWriteData),
        .MemWriteEn   (MemWriteEn),
        .MemReadEn    (MemReadEn),
        .MemReadData  (MemReadData),
        .LoadData     (LoadData),
        .Stall        (Stall),
        .AlignErr     (AlignErr)
    );

    always #5 Clk = ~Clk;

    assign MemReadData = mem[MemAddress[7:2]];

    always @(posedge Clk) begin
        if (MemWriteEn) mem[MemAddress[7:2]] <= MemWriteData;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Apply a request at the falling edge and let outputs settle.
    task automatic drive(input logic w, input logic r, input logic [1:0] sz,
                         input logic sx, input logic [31:0] a, input logic [31:0] wd);
        @(negedge Clk);
        MemWrite  = w;
        MemRead   = r;
        Size      = sz;
        SignExt   = sx;
        Address   = a;
        WriteData = wd;
        #1;
        $display("t=%0t req w=%0b r=%0b size=%0d sext=%0b addr=%08h wdata=%08h -> ld=%08h stall=%0b aerr=%0b",
                 $time, w, r, sz, sx, a, wd, LoadData, Stall, AlignErr);
    endtask

    task automatic hold_cycle();
        @(negedge Clk);
        #1;
        $display("t=%0t hold -> wen=%0b wdata=%08h stall=%0b", $time, MemWriteEn, MemWriteData, Stall);
    endtask

    task automatic sw(input logic [31:0] a, input logic [31:0] d);
        drive(1'b1, 1'b0, 2'b00, 1'b0, a, d);
    endtask

    task automatic lw_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        drive(1'b0, 1'b1, 2'b00, 1'b0, a, 32'h0);
        chk(tag, LoadData, exp);
    endtask

    initial begin
        // Reset with a misaligned word store pending: everything forced low.
        Reset = 1'b1; MemWrite = 1'b1; MemRead = 1'b0; Size = 2'b00;
        SignExt = 1'b0; Address = 32'h13; WriteData = 32'hFFFF_FFFF;
        #2;
        chk("rst_wen",   {31'b0, MemWriteEn}, 32'h0);
        chk("rst_aerr",  {31'b0, AlignErr},   32'h0);
        chk("rst_stall", {31'b0, Stall},      32'h0);
        @(negedge Clk);
        Reset = 1'b0; MemWrite = 1'b0;

        // 1: word store / word load
        sw(32'h10, 32'hDEADBEEF);
        chk("sw_wen",   {31'b0, MemWriteEn}, 32'h1);
        chk("sw_wdata", MemWriteData, 32'hDEADBEEF);
        chk("sw_stall", {31'b0, Stall}, 32'h0);
        chk("sw_maddr", MemAddress, 32'h10);
        lw_chk("lw_10", 32'h10, 32'hDEADBEEF);
        chk("lw_ren",   {31'b0, MemReadEn}, 32'h1);
        chk("lw_stall", {31'b0, Stall}, 32'h0);

        // 2: sub-word loads
        sw(32'h20, 32'h882233F4);
        sw(32'h24, 32'h00000000);
        drive(1'b0, 1'b1, 2'b10, 1'b1, 32'h20, 32'h0); chk("lb_20",  LoadData, 32'hFFFFFFF4);
        drive(1'b0, 1'b1, 2'b10, 1'b0, 32'h20, 32'h0); chk("lbu_20", LoadData, 32'h000000F4);
        drive(1'b0, 1'b1, 2'b01, 1'b1, 32'h22, 32'h0); chk("lh_22",  LoadData, 32'hFFFF8822);
        drive(1'b0, 1'b1, 2'b01, 1'b0, 32'h22, 32'h0); chk("lhu_22", LoadData, 32'h00008822);
        drive(1'b0, 1'b1, 2'b10, 1'b1, 32'h21, 32'h0); chk("lb_21",  LoadData, 32'h00000033);

        // 3: sb 0xAB to 0x21 over 0x11223344
        sw(32'h20, 32'h11223344);
        drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h21, 32'h123456AB);
        chk("sb_c1_stall", {31'b0, Stall},      32'h1);
        chk("sb_c1_ren",   {31'b0, MemReadEn},  32'h1);
        chk("sb_c1_wen",   {31'b0, MemWriteEn}, 32'h0);
        hold_cycle();
        chk("sb_c2_wen",   {31'b0, MemWriteEn}, 32'h1);
        chk("sb_c2_wdata", MemWriteData, 32'h1122AB44);
        chk("sb_c2_stall", {31'b0, Stall}, 32'h0);
        chk("sb_c2_ren",   {31'b0, MemReadEn}, 32'h0);
        lw_chk("lw_after_sb", 32'h20, 32'h1122AB44);

        // 4: sh 0x5566 to 0x22, then sb 0x77 to 0x24 back to back
        sw(32'h20, 32'h11223344);
        drive(1'b1, 1'b0, 2'b01, 1'b0, 32'h22, 32'hCCCC5566);
        chk("sh_c1_stall", {31'b0, Stall}, 32'h1);
        hold_cycle();
        chk("sh_c2_wdata", MemWriteData, 32'h55663344);
        drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h24, 32'h00000077);
        chk("sb24_c1_stall", {31'b0, Stall}, 32'h1);
        hold_cycle();
        chk("sb24_c2_wdata", MemWriteData, 32'h00000077);
        lw_chk("lw_20_sh", 32'h20, 32'h55663344);
        lw_chk("lw_24_sb", 32'h24, 32'h00000077);

        // 5: misaligned accesses
        drive(1'b0, 1'b1, 2'b00, 1'b0, 32'h12, 32'h0);
        chk("lw12_aerr", {31'b0, AlignErr},  32'h1);
        chk("lw12_ren",  {31'b0, MemReadEn}, 32'h0);
        chk("lw12_ld",   LoadData, 32'h0);
        drive(1'b1, 1'b0, 2'b01, 1'b0, 32'h21, 32'h0000BEEF);
        chk("sh21_aerr",  {31'b0, AlignErr},   32'h1);
        chk("sh21_wen",   {31'b0, MemWriteEn}, 32'h0);
        chk("sh21_stall", {31'b0, Stall},      32'h0);
        lw_chk("lw_after_sh21", 32'h20, 32'h55663344);
        drive(1'b0, 1'b1, 2'b10, 1'b1, 32'h23, 32'h0);
        chk("lb23_aerr", {31'b0, AlignErr}, 32'h0);
        chk("lb23_ld",   LoadData, 32'h00000055);

        // 6: reset during MERGE abandons the write
        sw(32'h20, 32'h11223344);
        drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h21, 32'h000000AB);
        chk("rm_c1_stall", {31'b0, Stall}, 32'h1);
        hold_cycle();
        chk("rm_c2_wen_pre", {31'b0, MemWriteEn}, 32'h1);
        Reset = 1'b1;
        #1;
        chk("rm_wen_drop", {31'b0, MemWriteEn}, 32'h0);
        chk("rm_stall",    {31'b0, Stall},      32'h0);
        @(negedge Clk);
        Reset = 1'b0; MemWrite = 1'b0; MemRead = 1'b0;
        #1;
        chk("rm_rel_stall", {31'b0, Stall},      32'h0);
        chk("rm_rel_wen",   {31'b0, MemWriteEn}, 32'h0);
        lw_chk("lw_after_rst", 32'h20, 32'h11223344);
        chk("rm_idle_ren", {31'b0, MemReadEn}, 32'h1);

        @(negedge Clk);
        MemRead = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

MEM-stage load/store controller sitting between the EX/MEM pipeline register and `DataMemory`. It converts word, halfword and byte loads and stores into word-wide `DataMemory` accesses. Sub-word loads are extracted with sign or zero extension. Sub-word stores run as a two-cycle read-modify-write, and the pipeline is stalled for one cycle while that happens.

## Interface
Parameters:
- `ADDR_W`, 32: width of the byte address.

Ports:
- `Clk`  in  1  clock; all state updates on the rising edge.
- `Reset`  in  1  asynchronous reset, active-high.
- `Address`  in  ADDR_W  byte address from EX/MEM.
- `WriteData`  in  32  store data from EX/MEM; the sub-word is in the low bits.
- `MemWrite`  in  1  store request.
- `MemRead`  in  1  load request.
- `Size`  in  2  access size: 00 = word, 01 = halfword, 10 = byte, 11 = reserved (treated as word).
- `SignExt`  in  1  1 = sign-extend a sub-word load, 0 = zero-extend.
- `MemAddress`  out  ADDR_W  word-aligned address to `DataMemory`: {`Address[ADDR_W-1:2]`, 2'b00}.
- `MemWriteData`  out  32  word written to `DataMemory`.
- `MemWriteEn`  out  1  `DataMemory` MemWrite.
- `MemReadEn`  out  1  `DataMemory` MemRead.
- `MemReadData`  in  32  `DataMemory` ReadData; combinational read.
- `LoadData`  out  32  extended load result to MEM/WB.
- `Stall`  out  1  1 = hold PC, IF/ID, ID/EX and EX/MEM this cycle.
- `AlignErr`  out  1  misaligned access this cycle.

## Operation
- Lane order is little-endian:
  - byte offset k occupies bits [8k+7:8k];
  - halfword offset 0 occupies [15:0] and offset 2 occupies [31:16].
- A request is a store if `MemWrite`=1; `MemWrite` wins over `MemRead`.
- A request is a load if `MemRead`=1 and `MemWrite`=0.
- Misaligned accesses:
  - word with `Address[1:0]`≠0, or halfword with `Address[0]`=1;
  - `AlignErr`=1 combinationally;
  - no memory enables, `LoadData`=0, `Stall`=0, FSM stays in IDLE.
- State machine, two states: IDLE and MERGE.
- In IDLE:
  - Word load: `MemReadEn`=1; `LoadData`=`MemReadData`; no stall.
  - Sub-word load: `MemReadEn`=1; the selected lane is extended by `SignExt` into `LoadData`; no stall.
  - Word store: `MemWriteEn`=1; `MemWriteData`=`WriteData`; no stall.
  - Sub-word store:
    - `MemReadEn`=1 and `Stall`=1;
    - on the edge, the merge register is loaded with `MemReadData`, with the target lane replaced by `WriteData[7:0]` or `WriteData[15:0]`;
    - next state is MERGE.
  - No request: all enables 0 and `LoadData`=0.
- In MERGE:
  - `MemWriteEn`=1, `MemWriteData`=merge register, `MemReadEn`=0;
  - `Stall`=0 and `LoadData`=0;
  - next state is IDLE unconditionally.
  - The EX/MEM inputs are held stable by the stall, so `MemAddress` is unchanged.
  - A new request is not accepted in MERGE; EX/MEM advances on the MERGE edge.
- The merge register is 32 bits and is only written in IDLE on a sub-word store.

## Timing
- Reset, asynchronous:
  - state=IDLE and merge register=0 immediately;
  - while `Reset`=1, `MemWriteEn`, `MemReadEn`, `Stall` and `AlignErr` are forced to 0 and `LoadData` to 0.
- Reset during MERGE abandons the write: memory is unchanged and `Stall`=0 at once.
- Load latency: 0 cycles; `LoadData` is valid in the request cycle for capture by MEM/WB.
- Word store: `DataMemory` writes on the edge that ends the request cycle.
- Sub-word store takes 2 cycles:
  - cycle 1 reads with `Stall`=1;
  - cycle 2 writes on the edge ending MERGE.
- `Stall` is high for exactly one cycle per aligned sub-word store and never otherwise.
- Back-to-back sub-word stores: each costs 2 cycles with no dead cycle between them.
- A load immediately after a sub-word store reads the merged value, because the write commits on the MERGE edge.

## Test plan
1. Word store 0xDEADBEEF to 0x10, then word load from 0x10 -> `LoadData`=0xDEADBEEF and `Stall` is never 1.
2. With word 0x882233F4 preloaded at 0x20:
   - lb 0x20 signed -> 0xFFFFFFF4;
   - lbu 0x20 -> 0x000000F4;
   - lh 0x22 signed -> 0xFFFF8822;
   - lhu 0x22 -> 0x00008822.
3. With word 0x11223344 preloaded at 0x20, sb 0xAB to 0x21:
   - cycle 1: `Stall`=1, `MemReadEn`=1;
   - cycle 2: `MemWriteEn`=1, `MemWriteData`=0x1122AB44;
   - following lw 0x20 -> 0x1122AB44.
4. sh 0x5566 to 0x22 over 0x11223344 -> memory word 0x55663344; then sb to 0x24 issued immediately -> its stall begins in the next cycle.
5. lw 0x12 -> `AlignErr`=1, no enables, `LoadData`=0; sh 0x21 -> `AlignErr`=1, memory unchanged; lb 0x23 -> no error.
6. Assert `Reset` in the MERGE cycle of sb 0xAB to 0x21 over 0x11223344 -> `MemWriteEn` drops immediately, memory stays 0x11223344, and after release the FSM is in IDLE with `Stall`=0.
